float_norm_round: RTL and testbench

- Post-accumulation normalise/round/pack stage of the float matmul datapath.
- Takes an unnormalised sign/exponent/magnitude triple from the MAC accumulator, counts leading zeros, left-shifts, rounds to nearest-even and packs an IEEE-754 word.
- 3-stage pipeline with valid/ready handshakes on both sides; sits directly downstream of the accumulator and upstream of the result writeback.

---
 rtl/float_norm_round_pkg.sv | 24 ++
 rtl/float_norm_round_if.sv | 26 ++
 rtl/float_lzc.sv | 46 ++++
 rtl/float_round_pack.sv | 48 ++++
 rtl/float_norm_round.sv | 119 +++++++++++
 tb/tb_float_norm_round.sv | 255 +++++++++++++++++++++++++
 6 files changed

// File: rtl/float_norm_round_pkg.sv
// rtl/float_norm_round_pkg.sv - shared float constants and helpers for the normalise/round stage
package float_norm_round_pkg;

    localparam int DEF_EXP_WIDTH = 8;
    localparam int DEF_MAN_WIDTH = 23;
    localparam int DEF_ACC_WIDTH = 48;

    localparam int BIAS          = (1 << (DEF_EXP_WIDTH - 1)) - 1;
    localparam int LZC_WIDTH     = $clog2(DEF_ACC_WIDTH + 1);
    localparam int EXP_INT_WIDTH = DEF_EXP_WIDTH + 3;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    function automatic int bias_of(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int lzc_width_of(input int acc_width);
        return $clog2(acc_width + 1);
    endfunction

endpackage

// File: rtl/float_norm_round_if.sv
// rtl/float_norm_round_if.sv - upstream triple and downstream packed-result handshakes
interface float_norm_round_if #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int ACC_WIDTH = 48
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_sign;
    logic [EXP_WIDTH+1:0]           in_exp;
    logic [ACC_WIDTH-1:0]           in_mag;
    logic                           out_valid;
    logic                           out_ready;
    logic [EXP_WIDTH+MAN_WIDTH:0]   out_data;
    logic [2:0]                     out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/float_lzc.sv
// rtl/float_lzc.sv - grouped leading-zero counter; all-zero input yields WIDTH
module float_lzc #(
    parameter int WIDTH       = 48,
    parameter int GROUP_SIZE  = 8,
    parameter int OUTPUT_STEP = 1,
    parameter int OUTPUT_BIAS = 0,
    parameter int CNT_WIDTH   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     din,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam int NG = (WIDTH + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int PW = NG * GROUP_SIZE;

    logic [PW-1:0] padded;

    // Padding ones below the LSB make an all-zero input count exactly WIDTH.
    generate
        if (PW > WIDTH) begin : g_pad
            assign padded = {din, {(PW - WIDTH){1'b1}}};
        end else begin : g_nopad
            assign padded = din;
        end
    endgenerate

    always_comb begin : p_count
        int   raw;
        int   grp_lz;
        logic found;
        raw    = PW;
        grp_lz = 0;
        found  = 1'b0;
        for (int gi = NG - 1; gi >= 0; gi--) begin
            if (!found && (|padded[gi*GROUP_SIZE +: GROUP_SIZE])) begin
                found  = 1'b1;
                grp_lz = 0;
                for (int b = 0; b < GROUP_SIZE; b++) begin
                    if (padded[gi*GROUP_SIZE + b]) grp_lz = GROUP_SIZE - 1 - b;
                end
                raw = (NG - 1 - gi) * GROUP_SIZE + grp_lz;
            end
        end
        cnt = CNT_WIDTH'(raw * OUTPUT_STEP + OUTPUT_BIAS);
    end

endmodule

// File: rtl/float_round_pack.sv
// rtl/float_round_pack.sv - round-to-nearest-even, range check and IEEE-754 packing
module float_round_pack
    import float_norm_round_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                          sign,
    input  logic signed [EXP_WIDTH+2:0]   e,
    input  logic [MAN_WIDTH-1:0]          man,
    input  logic                          g,
    input  logic                          s,
    input  logic                          zero,
    output logic [EXP_WIDTH+MAN_WIDTH:0]  data,
    output logic [2:0]                    flags
);
    localparam int EIW = EXP_WIDTH + 3;
    localparam logic signed [EIW-1:0] EMAX = EIW'((1 << EXP_WIDTH) - 1);

    logic                  rup;
    logic [MAN_WIDTH:0]    man_sum;
    logic signed [EIW-1:0] e_r;

    assign rup     = g & (s | man[0]);
    assign man_sum = {1'b0, man} + {{MAN_WIDTH{1'b0}}, rup};
    // A carry out of the mantissa leaves man_sum[MAN_WIDTH-1:0] zero and bumps the exponent.
    assign e_r     = e + $signed({{(EIW - 1){1'b0}}, man_sum[MAN_WIDTH]});

    always_comb begin
        data  = '0;
        flags = '0;
        if (zero) begin
            data = {sign, {(EXP_WIDTH + MAN_WIDTH){1'b0}}};
        end else if (e_r >= EMAX) begin
            data            = {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            flags[FLAG_OVF] = 1'b1;
            flags[FLAG_INX] = 1'b1;
        end else if (e_r[EIW-1] || (e_r == '0)) begin
            data            = {sign, {(EXP_WIDTH + MAN_WIDTH){1'b0}}};
            flags[FLAG_UNF] = 1'b1;
            flags[FLAG_INX] = 1'b1;
        end else begin
            data            = {sign, e_r[EXP_WIDTH-1:0], man_sum[MAN_WIDTH-1:0]};
            flags[FLAG_INX] = g | s;
        end
    end

endmodule

// File: rtl/float_norm_round.sv
// rtl/float_norm_round.sv - 3-stage normalise/round/pack of accumulator triples
module float_norm_round
    import float_norm_round_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int ACC_WIDTH = 48,
    parameter int LZC_GROUP = 8
) (
    input logic               clk,
    input logic               rst_n,
    float_norm_round_if.slave bus
);
    localparam int LZW = lzc_width_of(ACC_WIDTH);
    localparam int EIW = EXP_WIDTH + 3;
    localparam logic signed [EIW-1:0] ONE = EIW'(1);

    logic adv1, adv2, adv3;

    logic                        v1, s1_sign, s1_zero;
    logic signed [EXP_WIDTH+1:0] s1_exp;
    logic [ACC_WIDTH-1:0]        s1_mag;
    logic [LZW-1:0]              s1_lz, lz;

    logic                        v2, s2_sign, s2_zero, s2_g, s2_s;
    logic signed [EIW-1:0]       s2_e, e_next;
    logic [MAN_WIDTH-1:0]        s2_man;

    logic [ACC_WIDTH-2:0]               frac;
    logic [EXP_WIDTH+MAN_WIDTH:0]       rp_data;
    logic [2:0]                         rp_flags;

    float_lzc #(
        .WIDTH       (ACC_WIDTH),
        .GROUP_SIZE  (LZC_GROUP),
        .OUTPUT_STEP (1),
        .OUTPUT_BIAS (0),
        .CNT_WIDTH   (LZW)
    ) u_lzc (
        .din (bus.in_mag),
        .cnt (lz)
    );

    // Each stage moves when it is empty or its successor moves, so bubbles collapse.
    assign adv3         = !bus.out_valid || bus.out_ready;
    assign adv2         = !v2 || adv3;
    assign adv1         = !v1 || adv2;
    assign bus.in_ready = adv1;

    // The hidden 1 lands on bit ACC_WIDTH-1 and is dropped from frac.
    assign frac   = (ACC_WIDTH - 1)'(s1_mag << s1_lz);
    assign e_next = $signed({s1_exp[EXP_WIDTH+1], s1_exp}) + ONE
                  - $signed({{(EIW - LZW){1'b0}}, s1_lz});

    float_round_pack #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_round_pack (
        .sign  (s2_sign),
        .e     (s2_e),
        .man   (s2_man),
        .g     (s2_g),
        .s     (s2_s),
        .zero  (s2_zero),
        .data  (rp_data),
        .flags (rp_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            s1_sign       <= 1'b0;
            s1_zero       <= 1'b0;
            s1_exp        <= '0;
            s1_mag        <= '0;
            s1_lz         <= '0;
            v2            <= 1'b0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_g          <= 1'b0;
            s2_s          <= 1'b0;
            s2_e          <= '0;
            s2_man        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_flags <= '0;
        end else begin
            if (adv1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign <= bus.in_sign;
                    s1_exp  <= bus.in_exp;
                    s1_mag  <= bus.in_mag;
                    s1_lz   <= lz;
                    s1_zero <= (bus.in_mag == '0);
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sign <= s1_sign;
                    s2_zero <= s1_zero;
                    s2_e    <= e_next;
                    s2_man  <= frac[ACC_WIDTH-2 -: MAN_WIDTH];
                    s2_g    <= frac[ACC_WIDTH-2-MAN_WIDTH];
                    s2_s    <= |frac[ACC_WIDTH-3-MAN_WIDTH:0];
                end
            end
            if (adv3) begin
                bus.out_valid <= v2;
                if (v2) begin
                    bus.out_data  <= rp_data;
                    bus.out_flags <= rp_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_norm_round.sv
// tb/tb_float_norm_round.sv - scoreboard bench for float_norm_round
module tb_float_norm_round;
    import float_norm_round_pkg::*;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int AW = 48;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_norm_round_if #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .ACC_WIDTH(AW)) bus ();

    float_norm_round #(
        .EXP_WIDTH (EW),
        .MAN_WIDTH (MW),
        .ACC_WIDTH (AW),
        .LZC_GROUP (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t popped;
    exp_t held;
    bit   held_v = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: locate the MSB, then round the discarded tail against a half-ULP threshold.
    function automatic exp_t model(input logic sign, input logic signed [EW+1:0] ex,
                                   input logic [AW-1:0] mag);
        exp_t r;
        int p;
        longint e;
        longint unsigned m, man, rem, half;
        bit up, inexact;
        r.data  = {sign, 31'b0};
        r.flags = 3'b000;
        if (mag == '0) return r;
        p = 0;
        for (int i = 0; i < AW; i++) if (mag[i]) p = i;
        m = 64'(mag);
        e = longint'(ex) - (AW - 2) + p;
        if (p >= MW) begin
            man     = (m >> (p - MW)) & ((64'd1 << MW) - 1);
            rem     = m & ((64'd1 << (p - MW)) - 1);
            half    = (p > MW) ? (64'd1 << (p - MW - 1)) : 64'd0;
            inexact = (rem != 0);
            up      = (p > MW) && ((rem > half) || ((rem == half) && man[0]));
        end else begin
            man     = (m << (MW - p)) & ((64'd1 << MW) - 1);
            inexact = 1'b0;
            up      = 1'b0;
        end
        man = man + 64'(up);
        if (man == (64'd1 << MW)) begin
            man = 0;
            e   = e + 1;
        end
        if (e >= 255) begin
            r.data  = {sign, 8'hFF, 23'b0};
            r.flags = 3'b101;
        end else if (e <= 0) begin
            r.data  = {sign, 31'b0};
            r.flags = 3'b011;
        end else begin
            r.data  = {sign, 8'(e), 23'(man)};
            r.flags = {2'b00, inexact};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready", bus.in_ready, !(sb.size() == 3 && !bus.out_ready));
            if (held_v) begin
                check("hold_data", bus.out_data, held.data);
                check("hold_flags", bus.out_flags, held.flags);
            end
            held_v     = bus.out_valid && !bus.out_ready;
            held.data  = bus.out_data;
            held.flags = bus.out_flags;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 1'b0);
                end else begin
                    popped = sb.pop_front();
                    check("out_data", bus.out_data, popped.data);
                    check("out_flags", bus.out_flags, popped.flags);
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_sign, bus.in_exp, bus.in_mag));
        end
    end

    task automatic send(input logic sg, input logic [EW+1:0] ex, input logic [AW-1:0] mg);
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sign  = sg;
        bus.in_exp   = ex;
        bus.in_mag   = mg;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", bus.in_ready, 1'b1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic measure_latency(input string tag);
        int lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check(tag, 64'(lat), 64'd3);
    endtask

    logic [AW-1:0] stall_mag [6];
    int  k;
    int  out_base;
    bit  saw_block;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mag    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_data", bus.out_data, 32'h0);
        check("reset_out_flags", bus.out_flags, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", bus.in_ready, 1'b1);

        send(1'b0, 10'd127, 48'h1 << 46);
        idle();
        measure_latency("latency_first");
        drain();

        send(1'b1, 10'd127, 48'h1 << 47);
        send(1'b0, 10'd127, (48'h1 << 46) | (48'h1 << 22));
        send(1'b0, 10'd127, (48'h1 << 46) | (48'h1 << 23) | (48'h1 << 22));
        send(1'b0, 10'd254, 48'h1 << 47);
        send(1'b0, 10'd1,   48'h1 << 45);
        send(1'b1, 10'd0,   48'h0);
        send(1'b0, 10'd127, {1'b0, {47{1'b1}}});
        send(1'b0, 10'd253, {48{1'b1}});
        idle();
        drain();

        for (int i = 0; i < 24; i++) begin
            send(1'($urandom), 10'($urandom_range(0, 300)) - 10'd10,
                 48'({$urandom(), $urandom()}) >> $urandom_range(0, 47));
        end
        idle();
        drain();

        for (int i = 0; i < 6; i++) stall_mag[i] = (48'h3 << (40 - i)) | 48'(i * 5);
        out_base  = n_out;
        k         = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            bus.out_ready = !(c >= 4 && c <= 9);
            if (k < 6) begin
                bus.in_valid = 1'b1;
                bus.in_sign  = k[0];
                bus.in_exp   = 10'(120 + k);
                bus.in_mag   = stall_mag[k];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (!bus.in_ready) saw_block = 1'b1;
            if (bus.in_valid && bus.in_ready) k++;
        end
        bus.out_ready = 1'b1;
        drain();
        check("stall_in_ready_dropped", saw_block, 1'b1);
        check("stall_accepted", 64'(k), 64'd6);
        check("stall_outputs", 64'(n_out - out_base), 64'd6);

        send(1'b0, 10'd100, 48'h1234_5678_9ABC);
        send(1'b1, 10'd130, 48'h0000_FFFF_0000);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_mid_out_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", bus.out_valid, 1'b0);
        end
        out_base = n_out;
        send(1'b1, 10'd127, 48'h1 << 46);
        idle();
        measure_latency("latency_after_reset");
        drain();
        check("post_reset_outputs", 64'(n_out - out_base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
